pipelined_addsub: RTL

PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

---
 rtl/pipelined_addsub.sv | 96 +++++++++
 1 files changed

// File: rtl/pipelined_addsub.sv
// Segmented-carry add/sub with optional saturation; STAGES-cycle latency, one op per cycle.
// The whole pipe advances only when the output slot is empty or taken; otherwise every stage holds.
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int SEG = WIDTH / STAGES;
  localparam int MSB = WIDTH - 1;

  // carry holds the carry into the next segment; operands ride along so segments stay aligned
  typedef struct packed {
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] sum;
    logic             carry;
  } stage_t;

  stage_t             feed    [STAGES];
  stage_t             st_d    [STAGES];
  stage_t             st_q    [STAGES];
  logic   [SEG:0]     seg_sum [STAGES];
  logic [STAGES-1:0]  vld_q;
  logic               advance;

  assign advance   = !vld_q[STAGES-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];

  always_comb begin
    feed[0]       = '0;
    feed[0].mode  = mode;
    feed[0].a     = A;
    feed[0].bx    = mode[0] ? ~B : B;
    feed[0].carry = mode[0];
    for (int k = 1; k < STAGES; k++) begin
      feed[k] = st_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      seg_sum[k] = {1'b0, feed[k].a[k*SEG +: SEG]} + {1'b0, feed[k].bx[k*SEG +: SEG]}
                 + {{SEG{1'b0}}, feed[k].carry};
      st_d[k]                   = feed[k];
      st_d[k].sum[k*SEG +: SEG] = seg_sum[k][SEG-1:0];
      st_d[k].carry             = seg_sum[k][SEG];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

  assign cout = st_q[STAGES-1].carry;
  assign ovf  = (st_q[STAGES-1].a[MSB] == st_q[STAGES-1].bx[MSB]) &&
                (st_q[STAGES-1].sum[MSB] != st_q[STAGES-1].a[MSB]);

  // Saturation direction follows the sign of A, since overflow always pushes away from it
  always_comb begin
    Sum = st_q[STAGES-1].sum;
    if (st_q[STAGES-1].mode[1] && ovf) begin
      Sum = st_q[STAGES-1].a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  assign zero = (Sum == '0);
  assign neg  = Sum[MSB];

endmodule
